// File: rtl/painterengine_gpu_colorconvert_pkg.sv
// Shared pixel-layout constants and types for the GPU colour converter.
package painterengine_gpu_color_pkg;

    localparam logic [1:0] MODE_ARGB = 2'b00;
    localparam logic [1:0] MODE_RGBA = 2'b01;
    localparam logic [1:0] MODE_ABGR = 2'b10;
    localparam logic [1:0] MODE_BGRA = 2'b11;

    localparam logic ORDER_RGB = 1'b0;
    localparam logic ORDER_BGR = 1'b1;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/painterengine_gpu_colorconvert_if.sv
// Pixel-in / FIFO-out bus of the colour converter; master = producer/consumer side.
interface painterengine_gpu_colorconvert_if #(
    parameter int AW = 4
);
    logic [31:0] i_wire_color;
    logic        i_wire_valid;
    logic [1:0]  i_wire_iargb_mode;
    logic        i_wire_oargb_mode;
    logic        i_wire_read;
    logic [31:0] o_wire_data_out;
    logic        o_wire_full;
    logic        o_wire_almost_full;
    logic        o_wire_empty;
    logic        o_wire_almost_empty;
    logic [AW:0] o_wire_count;

    modport master (
        output i_wire_color, i_wire_valid, i_wire_iargb_mode, i_wire_oargb_mode, i_wire_read,
        input  o_wire_data_out, o_wire_full, o_wire_almost_full, o_wire_empty,
               o_wire_almost_empty, o_wire_count
    );

    modport slave (
        input  i_wire_color, i_wire_valid, i_wire_iargb_mode, i_wire_oargb_mode, i_wire_read,
        output o_wire_data_out, o_wire_full, o_wire_almost_full, o_wire_empty,
               o_wire_almost_empty, o_wire_count
    );
endinterface

// File: rtl/painterengine_gpu_colorconvert_fifo.sv
// Single-clock FIFO with registered head word and registered occupancy flags.
module gpu_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rd_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          afull_o,
    output logic          empty_o,
    output logic          aempty_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_AFULL = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] rdata_q;
    logic          full_q, afull_q, empty_q, aempty_q;
    logic          wr_en, rd_en;

    // Full/empty gate the strobes, so a read on empty never competes with a write.
    assign wr_en = wr_i && !full_q;
    assign rd_en = rd_i && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
        end else begin
            if (wr_en) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (rd_en) begin
                rptr_q  <= rptr_q + AW'(1);
                rdata_q <= mem_q[rptr_q];
            end
            count_q  <= count_d;
            full_q   <= (count_d == CNT_FULL);
            afull_q  <= (count_d >= CNT_AFULL);
            empty_q  <= (count_d == '0);
            aempty_q <= (count_d <= CNT_ONE);
        end
    end

    assign rdata_o  = rdata_q;
    assign full_o   = full_q;
    assign afull_o  = afull_q;
    assign empty_o  = empty_q;
    assign aempty_o = aempty_q;
    assign count_o  = count_q;

endmodule

// File: rtl/painterengine_gpu_colorconvert.sv
// ARGB-family to 24-bit RGB/BGR converter (1-cycle latency) feeding an output FIFO.
module painterengine_gpu_colorconvert
    import painterengine_gpu_color_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input logic i_wire_clock,
    input logic i_wire_reset,
    painterengine_gpu_colorconvert_if.slave bus
);

    rgb_t        pix;
    logic [31:0] conv_d, conv_q;
    logic        conv_valid_q;

    always_comb begin
        pix = '0;
        case (bus.i_wire_iargb_mode)
            MODE_ARGB: pix = '{r: bus.i_wire_color[23:16], g: bus.i_wire_color[15:8],  b: bus.i_wire_color[7:0]};
            MODE_RGBA: pix = '{r: bus.i_wire_color[31:24], g: bus.i_wire_color[23:16], b: bus.i_wire_color[15:8]};
            MODE_ABGR: pix = '{r: bus.i_wire_color[7:0],   g: bus.i_wire_color[15:8],  b: bus.i_wire_color[23:16]};
            MODE_BGRA: pix = '{r: bus.i_wire_color[15:8],  g: bus.i_wire_color[23:16], b: bus.i_wire_color[31:24]};
            default:   pix = '0;
        endcase
    end

    always_comb begin
        conv_d = '0;
        if (bus.i_wire_oargb_mode == ORDER_BGR) begin
            conv_d = {8'h00, pix.b, pix.g, pix.r};
        end else begin
            conv_d = {8'h00, pix.r, pix.g, pix.b};
        end
    end

    // Data register only loads on valid pixels; idle cycles keep the last result.
    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            conv_q       <= '0;
            conv_valid_q <= 1'b0;
        end else begin
            conv_valid_q <= bus.i_wire_valid;
            if (bus.i_wire_valid) begin
                conv_q <= conv_d;
            end
        end
    end

    gpu_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (32)
    ) u_fifo (
        .clk_i    (i_wire_clock),
        .rst_i    (i_wire_reset),
        .wr_i     (conv_valid_q),
        .wdata_i  (conv_q),
        .rd_i     (bus.i_wire_read),
        .rdata_o  (bus.o_wire_data_out),
        .full_o   (bus.o_wire_full),
        .afull_o  (bus.o_wire_almost_full),
        .empty_o  (bus.o_wire_empty),
        .aempty_o (bus.o_wire_almost_empty),
        .count_o  (bus.o_wire_count)
    );

endmodule

// File: tb/tb_painterengine_gpu_colorconvert.sv
// Scoreboard bench for the colour converter + FIFO using hand-computed pixel results.
module tb_painterengine_gpu_colorconvert;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    painterengine_gpu_colorconvert_if #(.AW(4)) bus ();

    painterengine_gpu_colorconvert #(
        .DEPTH (16),
        .AW    (4)
    ) u_dut (
        .i_wire_clock (clk),
        .i_wire_reset (rst),
        .bus          (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] cur_exp;
    logic [31:0] mq [$];
    logic [31:0] sb [$];
    bit          pend_v;
    logic [31:0] pend_d;
    bit          live = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference occupancy model: one-stage pixel pipe, then a 16-entry queue.
    always @(posedge clk) begin
        bit rd_ok;
        bit wr_ok;
        if (rst) begin
            mq.delete();
            sb.delete();
            pend_v = 1'b0;
            pend_d = '0;
            live   = 1'b1;
        end else begin
            rd_ok = bus.i_wire_read && (mq.size() != 0);
            wr_ok = pend_v && (mq.size() != 16);
            if (rd_ok) sb.push_back(mq.pop_front());
            if (wr_ok) mq.push_back(pend_d);
            pend_v = bus.i_wire_valid;
            if (bus.i_wire_valid) pend_d = cur_exp;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("count", 32'(bus.o_wire_count), 32'(mq.size()));
            chk("full", 32'(bus.o_wire_full), 32'(mq.size() == 16));
            chk("almost_full", 32'(bus.o_wire_almost_full), 32'(mq.size() >= 15));
            chk("empty", 32'(bus.o_wire_empty), 32'(mq.size() == 0));
            chk("almost_empty", 32'(bus.o_wire_almost_empty), 32'(mq.size() <= 1));
            if (sb.size() != 0) chk("data_out", bus.o_wire_data_out, sb.pop_front());
        end
    end

    task automatic px(logic [31:0] c, logic [1:0] im, logic om, logic [31:0] e, logic r);
        @(posedge clk);
        #1;
        bus.i_wire_valid      = 1'b1;
        bus.i_wire_color      = c;
        bus.i_wire_iargb_mode = im;
        bus.i_wire_oargb_mode = om;
        bus.i_wire_read       = r;
        cur_exp               = e;
    endtask

    task automatic idle(logic r);
        @(posedge clk);
        #1;
        bus.i_wire_valid = 1'b0;
        bus.i_wire_read  = r;
    endtask

    initial begin
        rst                   = 1'b1;
        bus.i_wire_valid      = 1'b0;
        bus.i_wire_read       = 1'b0;
        bus.i_wire_color      = '0;
        bus.i_wire_iargb_mode = 2'b00;
        bus.i_wire_oargb_mode = 1'b0;
        cur_exp               = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_data_out", bus.o_wire_data_out, 32'h0);
        chk("reset_empty", 32'(bus.o_wire_empty), 32'd1);
        chk("reset_almost_empty", 32'(bus.o_wire_almost_empty), 32'd1);
        chk("reset_full", 32'(bus.o_wire_full), 32'd0);
        chk("reset_almost_full", 32'(bus.o_wire_almost_full), 32'd0);

        // Eight identical ARGB pixels, then drain
        repeat (8) px(32'h44332211, 2'b00, 1'b0, 32'h00332211, 1'b0);
        idle(1'b0); idle(1'b0);
        @(negedge clk);
        chk("count_after_8", 32'(bus.o_wire_count), 32'd8);
        repeat (8) idle(1'b1);
        idle(1'b0); idle(1'b0);

        // Mode/order vectors
        px(32'h44332211, 2'b00, 1'b1, 32'h00112233, 1'b0);
        px(32'h88776655, 2'b01, 1'b0, 32'h00887766, 1'b0);
        px(32'h88776655, 2'b10, 1'b0, 32'h00556677, 1'b0);
        px(32'h88776655, 2'b11, 1'b1, 32'h00887766, 1'b0);
        px(32'h88776655, 2'b01, 1'b1, 32'h00667788, 1'b0);
        idle(1'b0);
        repeat (6) idle(1'b1);
        idle(1'b0);

        // Reads on empty leave the head word alone
        idle(1'b1); idle(1'b1); idle(1'b0);
        @(negedge clk);
        chk("empty_read_data_out", bus.o_wire_data_out, 32'h00667788);
        chk("empty_read_count", 32'(bus.o_wire_count), 32'd0);

        // 32 pixels with no reads: only the first 16 survive
        repeat (8) px(32'h44332211, 2'b00, 1'b0, 32'h00332211, 1'b0);
        idle(1'b0);
        repeat (8) px(32'h88776655, 2'b00, 1'b0, 32'h00776655, 1'b0);
        repeat (8) px(32'h44332211, 2'b00, 1'b0, 32'h00332211, 1'b0);
        idle(1'b0);
        repeat (8) px(32'h88776655, 2'b00, 1'b0, 32'h00776655, 1'b0);
        idle(1'b0); idle(1'b0);
        @(negedge clk);
        chk("overflow_full", 32'(bus.o_wire_full), 32'd1);
        chk("overflow_count", 32'(bus.o_wire_count), 32'd16);
        repeat (18) idle(1'b1);
        idle(1'b0);
        @(negedge clk);
        chk("overflow_last_word", bus.o_wire_data_out, 32'h00776655);
        chk("overflow_drained", 32'(bus.o_wire_count), 32'd0);

        // Flag boundaries at 1 and 2, then concurrent read+write at 5
        px(32'hFF0A0B0C, 2'b00, 1'b0, 32'h000A0B0C, 1'b0);
        idle(1'b0); idle(1'b0);
        @(negedge clk);
        chk("cnt1_almost_empty", 32'(bus.o_wire_almost_empty), 32'd1);
        chk("cnt1_empty", 32'(bus.o_wire_empty), 32'd0);
        px(32'hEE1A1B1C, 2'b00, 1'b0, 32'h001A1B1C, 1'b0);
        idle(1'b0); idle(1'b0);
        @(negedge clk);
        chk("cnt2_almost_empty", 32'(bus.o_wire_almost_empty), 32'd0);
        px(32'h002A2B2C, 2'b00, 1'b0, 32'h002A2B2C, 1'b0);
        px(32'h113A3B3C, 2'b00, 1'b0, 32'h003A3B3C, 1'b0);
        px(32'h224A4B4C, 2'b00, 1'b0, 32'h004A4B4C, 1'b0);
        idle(1'b0); idle(1'b0);
        px(32'h01020304, 2'b00, 1'b0, 32'h00020304, 1'b1);
        px(32'h05060708, 2'b00, 1'b0, 32'h00060708, 1'b1);
        px(32'h090A0B0C, 2'b00, 1'b0, 32'h000A0B0C, 1'b1);
        idle(1'b0); idle(1'b0);
        @(negedge clk);
        chk("rw_count_held", 32'(bus.o_wire_count), 32'd5);
        repeat (6) idle(1'b1);
        idle(1'b0);

        // Almost-full boundary at 15
        for (int i = 0; i < 15; i++) begin
            px(32'hA0000000 | 32'(i), 2'b00, 1'b0, 32'(i), 1'b0);
        end
        idle(1'b0); idle(1'b0);
        @(negedge clk);
        chk("cnt15_almost_full", 32'(bus.o_wire_almost_full), 32'd1);
        chk("cnt15_full", 32'(bus.o_wire_full), 32'd0);

        // Reset mid-burst at count 10 with pixels in flight
        repeat (5) idle(1'b1);
        idle(1'b0);
        @(negedge clk);
        chk("pre_reset_count", 32'(bus.o_wire_count), 32'd10);
        px(32'h55667788, 2'b00, 1'b0, 32'h00667788, 1'b0);
        px(32'h55667788, 2'b00, 1'b0, 32'h00667788, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.i_wire_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_count", 32'(bus.o_wire_count), 32'd0);
        chk("post_reset_empty", 32'(bus.o_wire_empty), 32'd1);
        chk("post_reset_data_out", bus.o_wire_data_out, 32'h0);

        px(32'h11223344, 2'b00, 1'b0, 32'h00223344, 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("latency_not_yet", 32'(bus.o_wire_count), 32'd0);
        idle(1'b0);
        @(negedge clk);
        chk("latency_written", 32'(bus.o_wire_count), 32'd1);
        idle(1'b1);
        idle(1'b0);
        @(negedge clk);
        chk("latency_word", bus.o_wire_data_out, 32'h00223344);

        idle(1'b0); idle(1'b0);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
